// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-lite decode stage.
//   Opcode/funct constants, ALU operation encodings and the control bundle
//   produced by ctrl_decode and consumed by id_ex_stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    memtoreg;
    logic    branch;
    logic    uses_rs;
    logic    uses_rt;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_ctrl_decode.sv
// ctrl_decode: combinational instruction word -> control bundle.
//   instr : 32-bit instruction word
//   ctrl  : decoded control bundle; an all-zero word decodes as a legal nop,
//           anything undecodable returns only the illegal flag set.
module ctrl_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.uses_rs  = 1'b1;
        ctrl.uses_rt  = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl.alu_src  = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.uses_rs  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src  = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.uses_rs  = 1'b1;
        ctrl.uses_rt  = 1'b1;   // rt carries the store data
      end
      OP_BEQ: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.branch  = 1'b1;
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.uses_rs  = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // Illegal words carry no side effects and never create a hazard.
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end

    // The all-zero word is R-type with funct 0; treat it as a nop, not illegal.
    if (instr == 32'd0) begin
      ctrl = '0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: back half of instruction decode plus the ID/EX pipeline register.
//   clk, rst_n            : clock, synchronous active-low reset
//   if_id_*               : instruction, valid and PC+4 from IF/ID
//   rn1, rn2 / rd1, rd2   : register-file read addresses / read data
//   wb_regwrite/wn/wd     : WB-stage write port, bypassed into the operands
//   flush                 : EX resolved a taken branch, squash the ID instruction
//   stall                 : load-use hazard, hold PC and IF/ID this cycle
//   ex_*                  : registered operands and control for the EX stage
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_id_valid,
  input  logic [DW-1:0] if_id_instr,
  input  logic [DW-1:0] if_id_pc4,
  output logic [RW-1:0] rn1,
  output logic [RW-1:0] rn2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_wn,
  input  logic [DW-1:0] wb_wd,
  input  logic          flush,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_wn,
  output logic [2:0]    ex_alu_op,
  output logic          ex_alu_src,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_branch,
  output logic          ex_illegal
);

  ctrl_t         ctrl;
  logic [5:0]    opcode;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic [RW-1:0] rd;
  logic [RW-1:0] wn;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] imm;
  logic          hazard;
  logic          take;

  ctrl_decode u_ctrl_decode (
    .instr (if_id_instr[31:0]),
    .ctrl  (ctrl)
  );

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];
  assign rn1    = rs;
  assign rn2    = rt;
  assign imm    = {{(DW-16){if_id_instr[15]}}, if_id_instr[15:0]};

  always_comb begin
    wn = '0;
    case (opcode)
      OP_RTYPE:       wn = rd;
      OP_LW, OP_ADDI: wn = rt;
      default:        wn = '0;
    endcase
    if (ctrl.illegal) wn = '0;
  end

  // Register file writes and reads in the same cycle, so WB data overrides
  // a stale read. Register 0 always reads as zero.
  always_comb begin
    op_a = rd1;
    if (rs == '0)                           op_a = '0;
    else if (wb_regwrite && (wb_wn == rs))  op_a = wb_wd;
    op_b = rd2;
    if (rt == '0)                           op_b = '0;
    else if (wb_regwrite && (wb_wn == rt))  op_b = wb_wd;
  end

  assign hazard = if_id_valid & ex_valid & ex_memread & (ex_wn != '0) &
                  ((ctrl.uses_rs & (ex_wn == rs)) | (ctrl.uses_rt & (ex_wn == rt)));
  assign stall  = hazard & ~flush;
  assign take   = if_id_valid & ~flush & ~hazard & ~ctrl.illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_pc4      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_wn       <= '0;
      ex_alu_op   <= '0;
      ex_alu_src  <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_branch   <= 1'b0;
      ex_illegal  <= 1'b0;
    end else begin
      // Data fields follow IF/ID even on bubbles; ex_valid qualifies them.
      ex_a        <= op_a;
      ex_b        <= op_b;
      ex_imm      <= imm;
      ex_pc4      <= if_id_pc4;
      ex_rs       <= rs;
      ex_rt       <= rt;
      ex_valid    <= take;
      ex_wn       <= take ? wn : '0;
      ex_alu_op   <= take ? ctrl.alu_op : '0;
      ex_alu_src  <= take & ctrl.alu_src;
      ex_regwrite <= take & ctrl.regwrite & (wn != '0);
      ex_memread  <= take & ctrl.memread;
      ex_memwrite <= take & ctrl.memwrite;
      ex_memtoreg <= take & ctrl.memtoreg;
      ex_branch   <= take & ctrl.branch;
      ex_illegal  <= if_id_valid & ctrl.illegal & ~flush & ~hazard;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [4:0]  rn1, rn2;
  logic [31:0] rd1, rd2;
  logic        wb_regwrite;
  logic [4:0]  wb_wn;
  logic [31:0] wb_wd;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_wn;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src, ex_regwrite, ex_memread, ex_memwrite;
  logic        ex_memtoreg, ex_branch, ex_illegal;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .rn1(rn1), .rn2(rn2), .rd1(rd1), .rd2(rd2),
    .wb_regwrite(wb_regwrite), .wb_wn(wb_wn), .wb_wd(wb_wd), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wn(ex_wn),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       legal;
    logic [2:0] op;
    logic       src, rw, mr, mw, mtr, br, use_rs, use_rt;
    logic [4:0] wn;
  } dec_t;

  function automatic dec_t ref_decode(logic [31:0] ins);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    if (ins == 32'd0) return d;
    case (ins[31:26])
      6'h00: begin
        d.rw = 1; d.use_rs = 1; d.use_rt = 1; d.wn = ins[15:11];
        case (ins[5:0])
          6'h20: d.op = 0;
          6'h22: d.op = 1;
          6'h24: d.op = 2;
          6'h25: d.op = 3;
          6'h2A: d.op = 4;
          default: d.legal = 0;
        endcase
      end
      6'h23: begin d.src = 1; d.mr = 1; d.mtr = 1; d.rw = 1; d.use_rs = 1; d.wn = ins[20:16]; end
      6'h2B: begin d.src = 1; d.mw = 1; d.use_rs = 1; d.use_rt = 1; end
      6'h04: begin d.op = 1; d.br = 1; d.use_rs = 1; d.use_rt = 1; end
      6'h08: begin d.src = 1; d.rw = 1; d.use_rs = 1; d.wn = ins[20:16]; end
      default: d.legal = 0;
    endcase
    if (!d.legal) d = '0;
    return d;
  endfunction

  function automatic logic [31:0] ref_operand(logic [4:0] n, logic [31:0] rdata);
    if (n == 0) return 32'd0;
    if (wb_regwrite && wb_wn == n) return wb_wd;
    return rdata;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  s, t, d;
    logic [15:0] im;
    logic [5:0]  fn [5];
    fn[0] = 6'h20; fn[1] = 6'h22; fn[2] = 6'h24; fn[3] = 6'h25; fn[4] = 6'h2A;
    s  = 5'($urandom_range(0, 7));
    t  = 5'($urandom_range(0, 7));
    d  = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 1, 2, 3, 4: return {6'h00, s, t, d, 5'd0, fn[$urandom_range(0, 4)]};
      5:  return {6'h23, s, t, im};
      6:  return {6'h2B, s, t, im};
      7:  return {6'h04, s, t, im};
      8:  return {6'h08, s, t, im};
      9:  return 32'd0;
      10: return {6'h3F, s, t, im};
      default: return {6'h00, s, t, d, 5'd0, 6'h21};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    rst_n = 0; if_id_valid = 1; if_id_instr = 32'h00221820; if_id_pc4 = 32'h104;
    rd1 = 32'd11; rd2 = 32'd22; wb_regwrite = 0; wb_wn = 0; wb_wd = 0; flush = 0;
    tick(); tick();
    checks++;
    if ({ex_valid, ex_a, ex_b, ex_imm, ex_pc4, ex_rs, ex_rt, ex_wn, ex_alu_op, ex_alu_src,
         ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_illegal} !== '0) begin
      errors++; $display("FAIL reset_zero got valid=%0d a=%h wn=%0d rw=%0d want all 0", ex_valid, ex_a, ex_wn, ex_regwrite);
    end
    rst_n = 1;
    tick();
    checks++;
    if ({ex_valid, ex_wn, ex_alu_op, ex_regwrite} !== {1'b1, 5'd3, 3'd0, 1'b1}) begin
      errors++; $display("FAIL reset_release got valid=%0d wn=%0d op=%0d rw=%0d want 1 3 0 1", ex_valid, ex_wn, ex_alu_op, ex_regwrite);
    end
  endtask

  task automatic test_bypass();
    if_id_instr = 32'h00221820; rd1 = 32'd5; rd2 = 32'd7;
    wb_regwrite = 1; wb_wn = 5'd1; wb_wd = 32'd99;
    #1;
    checks++;
    if ({rn1, rn2} !== {5'd1, 5'd2}) begin
      errors++; $display("FAIL read_addr got %0d,%0d want 1,2", rn1, rn2);
    end
    tick();
    checks++;
    if ({ex_a, ex_b} !== {32'd99, 32'd7}) begin
      errors++; $display("FAIL bypass_a got a=%0d b=%0d want 99 7", ex_a, ex_b);
    end
    wb_wn = 5'd0;
    tick();
    checks++;
    if (ex_a !== 32'd5) begin
      errors++; $display("FAIL bypass_wn0 got a=%0d want 5", ex_a);
    end
    wb_wn = 5'd2;
    tick();
    checks++;
    if ({ex_a, ex_b} !== {32'd5, 32'd99}) begin
      errors++; $display("FAIL bypass_b got a=%0d b=%0d want 5 99", ex_a, ex_b);
    end
    if_id_instr = 32'h00021820; wb_wn = 5'd0;
    tick();
    checks++;
    if (ex_a !== 32'd0) begin
      errors++; $display("FAIL bypass_r0 got a=%0d want 0", ex_a);
    end
    wb_regwrite = 0;
  endtask

  task automatic test_load_use();
    logic [31:0] users [3];
    users[0] = 32'h00822820;  // add $5,$4,$2 after lw $4
    users[1] = 32'h20C50001;  // addi $5,$6,1 after lw $6
    users[2] = 32'hAC260000;  // sw $6,0($1) after lw $6
    for (int i = 0; i < 3; i++) begin
      if_id_valid = 1;
      if_id_instr = (i == 0) ? 32'h8C240008 : 32'h8C260008;
      tick();
      if_id_instr = users[i];
      #1;
      checks++;
      if (stall !== 1'b1) begin
        errors++; $display("FAIL lu_stall%0d got %0d want 1", i, stall);
      end
      tick();
      checks++;
      if ({ex_valid, ex_regwrite, ex_memread, stall} !== 4'b0000) begin
        errors++; $display("FAIL lu_bubble%0d got valid=%0d rw=%0d mr=%0d stall=%0d want 0 0 0 0", i, ex_valid, ex_regwrite, ex_memread, stall);
      end
      tick();
      checks++;
      if ({ex_valid, ex_rs} !== {1'b1, users[i][25:21]}) begin
        errors++; $display("FAIL lu_resume%0d got valid=%0d rs=%0d want 1 %0d", i, ex_valid, ex_rs, users[i][25:21]);
      end
    end
    // addi whose rt equals the load destination: rt is not a source, no stall
    if_id_instr = 32'h8C260008;
    tick();
    if_id_instr = 32'h20260001;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_addi_rt got %0d want 0", stall);
    end
    // invalid IF/ID never stalls
    if_id_instr = 32'h8C260008;
    tick();
    if_id_valid = 0; if_id_instr = 32'h20C50001;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_invalid got %0d want 0", stall);
    end
    tick();
    if_id_valid = 1;
  endtask

  task automatic test_flush();
    if_id_instr = 32'h8C240008;
    tick();
    if_id_instr = 32'h00822820; flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL flush_stall got %0d want 0", stall);
    end
    tick();
    checks++;
    if ({ex_valid, ex_regwrite} !== 2'b00) begin
      errors++; $display("FAIL flush_bubble got valid=%0d rw=%0d want 0 0", ex_valid, ex_regwrite);
    end
    if_id_instr = 32'hFC000000;
    tick();
    checks++;
    if (ex_illegal !== 1'b0) begin
      errors++; $display("FAIL flush_illegal got %0d want 0", ex_illegal);
    end
    flush = 0;
  endtask

  task automatic test_decode();
    if_id_instr = 32'h1022FFFC;
    tick();
    checks++;
    if ({ex_valid, ex_branch, ex_alu_op, ex_imm, ex_wn, ex_regwrite} !== {1'b1, 1'b1, 3'd1, 32'hFFFFFFFC, 5'd0, 1'b0}) begin
      errors++; $display("FAIL dec_beq got v=%0d br=%0d op=%0d imm=%h wn=%0d rw=%0d want 1 1 1 fffffffc 0 0", ex_valid, ex_branch, ex_alu_op, ex_imm, ex_wn, ex_regwrite);
    end
    if_id_instr = 32'hFC000000;
    tick();
    checks++;
    if ({ex_illegal, ex_valid} !== 2'b10) begin
      errors++; $display("FAIL dec_illegal_op got ill=%0d valid=%0d want 1 0", ex_illegal, ex_valid);
    end
    if_id_instr = 32'h00000000;
    tick();
    checks++;
    if ({ex_illegal, ex_valid, ex_regwrite} !== 3'b010) begin
      errors++; $display("FAIL dec_nop got ill=%0d valid=%0d rw=%0d want 0 1 0", ex_illegal, ex_valid, ex_regwrite);
    end
    if_id_instr = 32'h00221821;
    tick();
    checks++;
    if ({ex_illegal, ex_valid} !== 2'b10) begin
      errors++; $display("FAIL dec_illegal_fn got ill=%0d valid=%0d want 1 0", ex_illegal, ex_valid);
    end
    if_id_instr = 32'h00000000;
    tick();
  endtask

  // ---------------- randomized test ----------------
  task automatic test_random();
    logic        m_valid, m_mr;
    logic [4:0]  m_wn;
    logic        hold, haz, e_stall, e_valid, e_ill, e_rw;
    logic [31:0] e_a, e_b, e_imm;
    dec_t        d;
    logic [11:0] e_ctrl, got_ctrl;
    logic [142:0] e_data, got_data;
    rst_n = 0; flush = 0;
    tick();
    rst_n = 1;
    m_valid = 0; m_mr = 0; m_wn = 0; hold = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!hold) begin
        if_id_instr = gen_instr();
        if_id_valid = ($urandom_range(0, 9) != 0);
        if_id_pc4   = $urandom;
      end
      rd1 = $urandom; rd2 = $urandom; wb_wd = $urandom;
      wb_regwrite = $urandom_range(0, 1) == 1;
      wb_wn = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 59) != 0);
      #1;
      d = ref_decode(if_id_instr);
      haz = if_id_valid && m_valid && m_mr && m_wn != 0 &&
            ((d.use_rs && m_wn == if_id_instr[25:21]) || (d.use_rt && m_wn == if_id_instr[20:16]));
      e_stall = haz && !flush;
      checks++;
      if (stall !== e_stall) begin
        errors++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", cyc, stall, e_stall);
      end
      e_a   = ref_operand(if_id_instr[25:21], rd1);
      e_b   = ref_operand(if_id_instr[20:16], rd2);
      e_imm = 32'($signed(if_id_instr[15:0]));
      e_valid = rst_n && if_id_valid && !flush && !haz && d.legal;
      e_ill   = rst_n && if_id_valid && !flush && !d.legal;
      e_rw    = e_valid && d.rw && d.wn != 0;
      if (e_valid) e_ctrl = {1'b1, d.op, d.src, e_rw, d.mr, d.mw, d.mtr, d.br, 1'b0, 1'b0};
      else         e_ctrl = '0;
      e_ctrl[0] = e_ill;
      e_data = {e_a, e_b, e_imm, if_id_pc4, if_id_instr[25:21], if_id_instr[20:16], d.wn};
      hold = e_stall;
      tick();
      got_ctrl = {ex_valid, ex_alu_op, ex_alu_src, ex_regwrite, ex_memread, ex_memwrite,
                  ex_memtoreg, ex_branch, 1'b0, ex_illegal};
      checks++;
      if (got_ctrl !== e_ctrl) begin
        errors++; $display("FAIL rnd_ctrl cyc %0d instr %h got %b want %b", cyc, if_id_instr, got_ctrl, e_ctrl);
      end
      if (e_valid) begin
        got_data = {ex_a, ex_b, ex_imm, ex_pc4, ex_rs, ex_rt, ex_wn};
        checks++;
        if (got_data !== e_data) begin
          errors++; $display("FAIL rnd_data cyc %0d instr %h got %h want %h", cyc, if_id_instr, got_data, e_data);
        end
      end
      m_valid = e_valid;
      m_mr    = e_valid && d.mr;
      m_wn    = e_valid ? d.wn : 5'd0;
    end
    rst_n = 1; flush = 0;
  endtask

  initial begin
    rst_n = 0; if_id_valid = 0; if_id_instr = 0; if_id_pc4 = 0;
    rd1 = 0; rd2 = 0; wb_regwrite = 0; wb_wn = 0; wb_wd = 0; flush = 0;
    tick();
    test_reset();
    test_bypass();
    test_load_use();
    test_flush();
    test_decode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
